// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell walks WIDTH operand bits,
// LSB first, behind a start/done handshake. The result {c_out,sum} equals
// a + b + c_in, and overflow flags a signed two's-complement overflow.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (x & ci) | (y & ci);
        return {co, s};
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shift_a_r;
    logic [WIDTH-1:0] shift_b_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             overflow_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [1:0]       fa_s;
    logic             accept_s;
    logic             last_bit_s;

    // Next-state decode, request acceptance and the adder cell itself.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        last_bit_s = 1'b0;
        fa_s       = full_add(shift_a_r[0], shift_b_r[0], carry_r);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_BIT) begin
                    last_bit_s = 1'b1;
                    state_s    = ST_DONE;
                end else begin
                    state_s    = ST_RUN;
                end
            end
            ST_DONE: begin
                // A start here chains straight into the next operation.
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, serial shifting, carry chain and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a_r  <= '0;
            shift_b_r  <= '0;
            carry_r    <= 1'b0;
            cnt_r      <= '0;
            sum_r      <= '0;
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (accept_s) begin
            shift_a_r <= a;
            shift_b_r <= b;
            carry_r   <= c_in;
            cnt_r     <= '0;
        end else if (state_r == ST_RUN) begin
            // Sum bits enter from the MSB side so bit 0 lands in place last.
            shift_a_r <= {1'b0, shift_a_r[WIDTH-1:1]};
            shift_b_r <= {1'b0, shift_b_r[WIDTH-1:1]};
            sum_r     <= {fa_s[0], sum_r[WIDTH-1:1]};
            carry_r   <= fa_s[1];
            cnt_r     <= cnt_r + CNT_W'(1);
            if (last_bit_s) begin
                // carry_r still holds the carry into the MSB at this edge.
                c_out_r    <= fa_s[1];
                overflow_r <= carry_r ^ fa_s[1];
            end
        end
    end

    // Handshake flags registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_s != ST_RUN);
            busy_r  <= (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign ready    = ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign c_out    = c_out_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the handshake
// scenarios and a 4-bit instance for an exhaustive arithmetic sweep.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;
    logic       overflow;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       c_in4;
    logic       ready4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       c_out4;
    logic       overflow4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .c_out(c_out),
        .overflow(overflow)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c_in4),
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4),
        .overflow(overflow4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the 8-bit unit and wait (bounded) for done.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_c,
                          output logic [7:0] r_sum, output logic r_co, output logic r_ov,
                          output int lat, output int busy_cnt);
        a = op_a; b = op_b; c_in = op_c; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 50) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        r_sum = sum; r_co = c_out; r_ov = overflow;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c_in4 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({ready, busy, done, sum, c_out, overflow} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got rdy=%b bsy=%b dn=%b sum=%h co=%b ov=%b expected 1 0 0 00 0 0",
                         i, ready, busy, done, sum, c_out, overflow);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co; logic ov; int lat; int bc;
        run_op(8'h5A, 8'h3C, 1'b0, s, co, ov, lat, bc);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d expected 8", lat); end
        checks++;
        if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d expected 8", bc); end
        checks++;
        if ({s, co, ov} !== {8'h96, 1'b0, 1'b1}) begin
            errors++; $display("FAIL basic_result got sum=%h co=%b ov=%b expected 96 0 1", s, co, ov);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({ready, busy, done, sum, c_out, overflow} !== {1'b1, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL basic_hold cyc=%0d got rdy=%b bsy=%b dn=%b sum=%h co=%b ov=%b expected 1 0 0 96 0 1",
                         i, ready, busy, done, sum, c_out, overflow);
            end
        end
    endtask

    task automatic test_carry_wrap();
        logic [7:0] s; logic co; logic ov; int lat; int bc;
        run_op(8'hFF, 8'h01, 1'b0, s, co, ov, lat, bc);
        checks++;
        if ({s, co, ov} !== {8'h00, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wrap_ff_01 got sum=%h co=%b ov=%b expected 00 1 0", s, co, ov);
        end
        tick();
        run_op(8'h7F, 8'h00, 1'b1, s, co, ov, lat, bc);
        checks++;
        if ({s, co, ov} !== {8'h80, 1'b0, 1'b1}) begin
            errors++; $display("FAIL wrap_7f_cin got sum=%h co=%b ov=%b expected 80 0 1", s, co, ov);
        end
        tick();
        run_op(8'h80, 8'h80, 1'b0, s, co, ov, lat, bc);
        checks++;
        if ({s, co, ov} !== {8'h00, 1'b1, 1'b1}) begin
            errors++; $display("FAIL wrap_80_80 got sum=%h co=%b ov=%b expected 00 1 1", s, co, ov);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int lat;
        a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 50) begin
            if (lat == 2) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL busy_start_latency got %0d expected 8", lat); end
        checks++;
        if ({sum, c_out} !== {8'h30, 1'b0}) begin
            errors++; $display("FAIL busy_start_result got sum=%h co=%b expected 30 0", sum, c_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int t; int d1; int d2; logic [7:0] r1; logic [7:0] r2;
        t = 0; d1 = -1; d2 = -1; r1 = 8'h00; r2 = 8'h00;
        a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
        while (d2 < 0 && t < 60) begin
            tick();
            t++;
            checks++;
            if (ready !== done || busy === ready) begin
                errors++;
                $display("FAIL b2b_ready t=%0d got rdy=%b bsy=%b dn=%b expected rdy==dn and bsy!=rdy",
                         t, ready, busy, done);
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = t; r1 = sum; a = 8'h03; b = 8'h04;
                end else begin
                    d2 = t; r2 = sum; start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (d2 < 0 || d2 - d1 !== 9) begin
            errors++; $display("FAIL b2b_spacing got d1=%0d d2=%0d expected spacing 9", d1, d2);
        end
        checks++;
        if (r1 !== 8'h03) begin errors++; $display("FAIL b2b_first got %h expected 03", r1); end
        checks++;
        if (r2 !== 8'h07) begin errors++; $display("FAIL b2b_second got %h expected 07", r2); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] s; logic co; logic ov; int lat; int bc; int seen;
        a = 8'h33; b = 8'h44; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ready, busy, done, sum, c_out, overflow} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_values got rdy=%b bsy=%b dn=%b sum=%h co=%b ov=%b expected 1 0 0 00 0 0",
                     ready, busy, done, sum, c_out, overflow);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles expected 0", seen); end
        run_op(8'hAA, 8'h55, 1'b1, s, co, ov, lat, bc);
        checks++;
        if ({s, co, ov} !== {8'h00, 1'b1, 1'b0} || lat !== 8) begin
            errors++; $display("FAIL midrst_after got sum=%h co=%b ov=%b lat=%0d expected 00 1 0 8", s, co, ov, lat);
        end
        tick();
    endtask

    task automatic test_sweep_w4();
        logic [4:0] exp_r; logic exp_ov; logic [3:0] op_a; logic [3:0] op_b; int lat;
        for (int i = 0; i < 512; i++) begin
            op_a = i[3:0]; op_b = i[7:4];
            a4 = op_a; b4 = op_b; c_in4 = i[8]; start4 = 1'b1;
            exp_r  = {1'b0, op_a} + {1'b0, op_b} + {4'h0, i[8]};
            exp_ov = (op_a[3] == op_b[3]) && (exp_r[3] != op_a[3]);
            tick();
            start4 = 1'b0;
            lat = 0;
            while (!done4 && lat < 20) begin
                tick();
                lat++;
            end
            checks++;
            if ({c_out4, sum4} !== exp_r || lat !== 4) begin
                errors++;
                $display("FAIL sweep_sum a=%h b=%h ci=%b got co=%b sum=%h lat=%0d expected %h lat=4",
                         op_a, op_b, i[8], c_out4, sum4, lat, exp_r);
            end
            checks++;
            if (overflow4 !== exp_ov) begin
                errors++;
                $display("FAIL sweep_ov a=%h b=%h ci=%b got %b expected %b", op_a, op_b, i[8], overflow4, exp_ov);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_wrap();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_sweep_w4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial addition controller. Sequences one combinational 1-bit full adder over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in.
- Gives the ripple-carry adder family a low-area alternative: one adder cell, shift registers and a carry flop, behind a start/done handshake.
- Sits between a requesting unit and any consumer of the sum/carry result.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
c_in  input  1  carry-in, captured on accepted start
ready  output  1  high when a new start will be accepted (IDLE or DONE)
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result; held stable from done until next accepted start
c_out  output  1  carry out of bit WIDTH-1
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE, ready=1, busy=0, done=0, sum=0, c_out=0, overflow=0. Internal shift registers, carry flop and bit counter are cleared.
- Reset mid-RUN: the operation is abandoned at that edge. No done is produced and all outputs take their reset values.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1: latch a into shift_a, b into shift_b, c_in into the carry flop, clear the bit counter, go to RUN.
- RUN:
  - busy=1, ready=0.
  - Each cycle, the full adder computes on shift_a[0], shift_b[0] and carry.
  - At the edge, the sum bit shifts into the result register from the MSB side (right shift), shift_a and shift_b shift right, carry takes the adder carry-out, and the counter increments.
  - On the edge that processes bit WIDTH-1: record carry-in-to-MSB (the carry value before that edge), load c_out and overflow, go to DONE.
  - RUN lasts exactly WIDTH cycles.
  - start during RUN is ignored. Operands are not re-sampled.
- DONE:
  - done=1 for exactly one cycle, ready=1.
  - If start=1 in this cycle: the new request is accepted (same capture as IDLE) and the next state is RUN. Back-to-back throughput is one result per WIDTH+1 cycles.
  - Otherwise go to IDLE.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E0+WIDTH (WIDTH+1 cycles from the request cycle).
- Result hold: sum, c_out and overflow keep their values through DONE and IDLE. They are cleared only by reset. During RUN the previous values are not guaranteed; the result register may be used as the shift target.
- Arithmetic: unsigned {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1). No saturation.
- busy and ready are never both 1. done=1 implies ready=1.
- Inputs a, b and c_in may change freely after the accepting edge without affecting the operation.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, then release with start=0 -> ready=1, busy=0, done=0, sum=0x00, c_out=0, overflow=0 steady for 20 cycles.
- Basic add, WIDTH=8: a=0x5A, b=0x3C, c_in=0, start for 1 cycle.
  - busy high for exactly 8 cycles.
  - done pulses in cycle 9 with sum=0x96, c_out=0, overflow=1.
  - Result held 10 further cycles.
- Carry/wrap: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0.
  - Then a=0x7F, b=0x00, c_in=1 -> sum=0x80, c_out=0, overflow=1.
  - Then a=0x80, b=0x80, c_in=0 -> sum=0x00, c_out=1, overflow=1.
- Start while busy: accept a=0x10, b=0x20. At RUN cycle 3, pulse start with a=0xFF, b=0xFF and change the a/b inputs -> ignored; done at the original latency with sum=0x30, c_out=0.
- Back-to-back: hold start=1 continuously with a=0x01, b=0x02, then a=0x03, b=0x04 on the DONE cycle.
  - done pulses exactly 9 cycles apart.
  - Results are 0x03 then 0x07.
  - ready=1 only on IDLE/DONE cycles.
- Reset mid-operation: assert rst for 1 cycle in RUN cycle 4 -> next cycle shows reset values, and no done pulse ever appears for that request.
  - A subsequent start with a=0xAA, b=0x55, c_in=1 -> sum=0x00, c_out=1, overflow=0.
- Exhaustive sweep with WIDTH=4: all 512 (a,b,c_in) combinations, each compared against a+b+c_in and against the signed-overflow reference.
